assoc_cache: RTL and testbench

Parametrised K-way set-associative word cache with one write channel and `RD_PORTS` independent read channels, valid tracking, synchronous flush and configurable replacement. It is the next generation of the team's two-channel cache. It adds true associativity with tag compare, allocation into invalid ways, victim selection and registered read results. It sits between the core-side request ports and the backing store model; misses are reported, never serviced internally.

---
 rtl/assoc_cache_pkg.sv | 36 +++
 rtl/assoc_cache_if.sv | 21 ++
 rtl/assoc_cache_set.sv | 117 +++++++++++
 rtl/assoc_cache.sv | 86 ++++++++
 tb/tb_assoc_cache.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/assoc_cache_pkg.sv
// Shared geometry, line storage type and replacement-state type for assoc_cache.
// ASSOC_CACHE_LRU_EN selects true-LRU ages; undefined selects a round-robin pointer.
package cache_pkg;
  localparam int DEF_SET_COUNT  = 4;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_LINE_WIDTH = 32;
  localparam int DEF_K          = 2;
  localparam int DEF_RD_PORTS   = 2;

  localparam int IDX_W  = $clog2(DEF_SET_COUNT);
  localparam int TAG_W  = DEF_ADDR_WIDTH - IDX_W;
  localparam int LINE_W = DEF_LINE_WIDTH;
  localparam int AGE_W  = $clog2(DEF_K);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } line_t;

`ifdef ASSOC_CACHE_LRU_EN
  typedef logic [DEF_K-1:0][AGE_W-1:0] repl_t;
`else
  typedef logic [AGE_W-1:0] repl_t;
`endif

  // LRU starts with way 0 as most recent; round-robin starts at way 0.
  function automatic repl_t repl_init();
    repl_t r;
    r = '0;
`ifdef ASSOC_CACHE_LRU_EN
    for (int w = 0; w < DEF_K; w++) r[w] = AGE_W'(w);
`endif
    return r;
  endfunction
endpackage

// File: rtl/assoc_cache_if.sv
// Request/response bundle between the core-side ports and assoc_cache.
interface assoc_cache_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int LINE_WIDTH = 32,
  parameter int RD_PORTS   = 2
);
  logic                                 flush;
  logic                                 wr_en;
  logic [ADDR_WIDTH-1:0]                wr_addr;
  logic [LINE_WIDTH-1:0]                wr_val;
  logic [RD_PORTS-1:0]                  rd_en;
  logic [RD_PORTS-1:0][ADDR_WIDTH-1:0]  rd_addr;
  logic [RD_PORTS-1:0]                  rd_valid;
  logic [RD_PORTS-1:0]                  rd_hit;
  logic [RD_PORTS-1:0][LINE_WIDTH-1:0]  rd_val;

  modport master (output flush, wr_en, wr_addr, wr_val, rd_en, rd_addr,
                  input  rd_valid, rd_hit, rd_val);
  modport slave  (input  flush, wr_en, wr_addr, wr_val, rd_en, rd_addr,
                  output rd_valid, rd_hit, rd_val);
endinterface

// File: rtl/assoc_cache_set.sv
// One cache set: K lines, tag compare for write and read channels, victim choice
// and replacement update (LRU ages with ASSOC_CACHE_LRU_EN, else round-robin).
module assoc_set
  import cache_pkg::*;
#(
  parameter int K        = DEF_K,
  parameter int RD_PORTS = DEF_RD_PORTS
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             wr_en,
  input  logic [TAG_W-1:0]                 wr_tag,
  input  logic [LINE_W-1:0]                wr_val,
  input  logic [RD_PORTS-1:0]              rd_en,
  input  logic [RD_PORTS-1:0][TAG_W-1:0]   rd_tag,
  output logic [RD_PORTS-1:0]              rd_hit,
  output logic [RD_PORTS-1:0][LINE_W-1:0]  rd_data
);
  line_t            lines [K];
  repl_t            repl;
  repl_t            repl_nxt;
  logic [AGE_W-1:0] victim;
  logic [AGE_W-1:0] tgt_way;
  logic [AGE_W-1:0] match_way;
  logic [AGE_W-1:0] inv_way;
  logic             wr_hit;
  logic             has_inv;

  always_comb begin
    rd_hit  = '0;
    rd_data = '0;
    for (int c = 0; c < RD_PORTS; c++) begin
      for (int w = 0; w < K; w++) begin
        if (rd_en[c] && lines[w].valid && lines[w].tag == rd_tag[c]) begin
          rd_hit[c]  = 1'b1;
          rd_data[c] = rd_data[c] | lines[w].data;
        end
      end
    end
  end

`ifdef ASSOC_CACHE_LRU_EN
  always_comb begin
    victim = '0;
    for (int w = 0; w < K; w++)
      if (repl[w] == AGE_W'(K - 1)) victim = AGE_W'(w);
  end
`else
  assign victim = repl;
`endif

  // Existing tag wins, then the lowest invalid way, then the victim.
  always_comb begin
    wr_hit    = 1'b0;
    match_way = '0;
    has_inv   = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < K; w++) begin
      if (lines[w].valid && lines[w].tag == wr_tag) begin
        wr_hit    = 1'b1;
        match_way = AGE_W'(w);
      end
    end
    for (int w = K - 1; w >= 0; w--) begin
      if (!lines[w].valid) begin
        has_inv = 1'b1;
        inv_way = AGE_W'(w);
      end
    end
    tgt_way = wr_hit ? match_way : (has_inv ? inv_way : victim);
  end

`ifdef ASSOC_CACHE_LRU_EN
  logic [RD_PORTS-1:0][AGE_W-1:0] rd_way;
  logic                           acc;
  logic [AGE_W-1:0]               acc_way;

  // Only the highest-priority access to this set ages the others.
  always_comb begin
    rd_way   = '0;
    acc      = 1'b0;
    acc_way  = '0;
    repl_nxt = repl;
    for (int c = 0; c < RD_PORTS; c++)
      for (int w = 0; w < K; w++)
        if (lines[w].valid && lines[w].tag == rd_tag[c]) rd_way[c] = AGE_W'(w);
    for (int c = RD_PORTS - 1; c >= 0; c--) begin
      if (rd_hit[c]) begin
        acc     = 1'b1;
        acc_way = rd_way[c];
      end
    end
    if (wr_en) begin
      acc     = 1'b1;
      acc_way = tgt_way;
    end
    if (acc) begin
      for (int w = 0; w < K; w++)
        if (repl[w] < repl[acc_way]) repl_nxt[w] = repl[w] + 1'b1;
      repl_nxt[acc_way] = '0;
    end
  end
`else
  assign repl_nxt = (wr_en && !wr_hit && !has_inv) ? repl + 1'b1 : repl;
`endif

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int w = 0; w < K; w++) lines[w].valid <= 1'b0;
      repl <= repl_init();
    end else begin
      if (wr_en) lines[tgt_way] <= '{valid: 1'b1, tag: wr_tag, data: wr_val};
      repl <= repl_nxt;
    end
  end
endmodule

// File: rtl/assoc_cache.sv
// assoc_cache: K-way set-associative word cache with RD_PORTS registered read channels.
// Build option ASSOC_CACHE_LRU_EN selects true-LRU replacement instead of round-robin.
module assoc_cache
  import cache_pkg::*;
#(
  parameter int SET_COUNT  = DEF_SET_COUNT,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LINE_WIDTH = DEF_LINE_WIDTH,
  parameter int K          = DEF_K,
  parameter int RD_PORTS   = DEF_RD_PORTS
) (
  input logic          clock,
  input logic          reset,
  assoc_cache_if.slave bus
);
  localparam int IW = $clog2(SET_COUNT);

  logic [IW-1:0]                          wr_idx;
  logic [TAG_W-1:0]                       wr_tag;
  logic [RD_PORTS-1:0][IW-1:0]            rd_idx;
  logic [RD_PORTS-1:0][TAG_W-1:0]         rd_tag;
  logic [SET_COUNT-1:0][RD_PORTS-1:0]     set_rd_en;
  logic [RD_PORTS-1:0]                    set_hit  [SET_COUNT];
  logic [RD_PORTS-1:0][LINE_W-1:0]        set_data [SET_COUNT];
  logic [RD_PORTS-1:0]                    hit_mux;
  logic [RD_PORTS-1:0][LINE_WIDTH-1:0]    data_mux;
  logic [RD_PORTS-1:0]                    rd_valid_q;
  logic [RD_PORTS-1:0]                    rd_hit_q;
  logic [RD_PORTS-1:0][LINE_WIDTH-1:0]    rd_val_q;

  assign wr_idx = bus.wr_addr[IW-1:0];
  assign wr_tag = bus.wr_addr[ADDR_WIDTH-1:IW];

  always_comb begin
    rd_idx    = '0;
    rd_tag    = '0;
    set_rd_en = '0;
    for (int c = 0; c < RD_PORTS; c++) begin
      rd_idx[c] = bus.rd_addr[c][IW-1:0];
      rd_tag[c] = bus.rd_addr[c][ADDR_WIDTH-1:IW];
      for (int s = 0; s < SET_COUNT; s++)
        set_rd_en[s][c] = bus.rd_en[c] && (rd_idx[c] == IW'(s));
    end
  end

  for (genvar s = 0; s < SET_COUNT; s++) begin : g_set
    assoc_set #(.K(K), .RD_PORTS(RD_PORTS)) u_set (
      .clock   (clock),
      .reset   (reset),
      .flush   (bus.flush),
      .wr_en   (bus.wr_en && (wr_idx == IW'(s))),
      .wr_tag  (wr_tag),
      .wr_val  (bus.wr_val),
      .rd_en   (set_rd_en[s]),
      .rd_tag  (rd_tag),
      .rd_hit  (set_hit[s]),
      .rd_data (set_data[s])
    );
  end

  // Set outputs are already gated by rd_en, so a miss or idle channel muxes to zero.
  always_comb begin
    hit_mux  = '0;
    data_mux = '0;
    for (int c = 0; c < RD_PORTS; c++) begin
      hit_mux[c]  = set_hit[rd_idx[c]][c];
      data_mux[c] = set_data[rd_idx[c]][c];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid_q <= '0;
      rd_hit_q   <= '0;
      rd_val_q   <= '0;
    end else begin
      rd_valid_q <= bus.rd_en;
      rd_hit_q   <= hit_mux;
      rd_val_q   <= data_mux;
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_hit   = rd_hit_q;
  assign bus.rd_val   = rd_val_q;
endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache: expected read results are queued at issue time
// and popped when rd_valid strobes; expectations follow the selected replacement build.
module tb_assoc_cache;
  typedef struct {
    int          chan;
    logic        hit;
    logic [31:0] val;
    int          id;
  } exp_t;

`ifdef ASSOC_CACHE_LRU_EN
  localparam bit LRU = 1'b1;
`else
  localparam bit LRU = 1'b0;
`endif

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  exp_t sb [$];
  exp_t e;
  logic [1:0] ev;

  assoc_cache_if #(.ADDR_WIDTH(8), .LINE_WIDTH(32), .RD_PORTS(2)) bus ();

  assoc_cache dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic w, input logic [7:0] wa, input logic [31:0] wv,
                     input logic [1:0] re, input logic [7:0] a0, input logic [7:0] a1,
                     input logic fl);
    @(negedge clk);
    bus.wr_en      = w;
    bus.wr_addr    = wa;
    bus.wr_val     = wv;
    bus.rd_en      = re;
    bus.rd_addr[0] = a0;
    bus.rd_addr[1] = a1;
    bus.flush      = fl;
  endtask

  task automatic expect_rd(input int c, input logic h, input logic [31:0] v, input int id);
    exp_t x;
    x.chan = c;
    x.hit  = h;
    x.val  = v;
    x.id   = id;
    sb.push_back(x);
  endtask

  // Output monitor: rd_valid must echo last cycle's non-reset rd_en; data checked against queue.
  always @(posedge clk) begin
    ev = bus.rd_en & {2{~rst}};
    #1;
    checks++;
    assert (bus.rd_valid === ev)
    else begin
      errors++;
      $error("FAIL rd_valid observed=%b expected=%b", bus.rd_valid, ev);
    end
    for (int c = 0; c < 2; c++) begin
      if (bus.rd_valid[c] === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $error("FAIL rd_ch%0d unexpected result observed hit=%b val=%h expected none",
                 c, bus.rd_hit[c], bus.rd_val[c]);
        end else begin
          e = sb.pop_front();
          assert (e.chan == c && bus.rd_hit[c] === e.hit && bus.rd_val[c] === e.val)
          else begin
            errors++;
            $error("FAIL rd_ch%0d id=%0d observed hit=%b val=%h expected ch=%0d hit=%b val=%h",
                   c, e.id, bus.rd_hit[c], bus.rd_val[c], e.chan, e.hit, e.val);
          end
        end
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_val = '0;
    bus.rd_en = '0;   bus.rd_addr = '0; bus.flush  = 1'b0;
    repeat (2) @(negedge clk);
    // Read issued during reset must produce no result.
    bus.rd_en = 2'b01; bus.rd_addr[0] = 8'h10;
    @(negedge clk);
    rst = 1'b0;
    bus.rd_en = 2'b00;
    @(posedge clk);
    #2;
    checks++;
    assert (bus.rd_hit === 2'b00 && bus.rd_val === 64'h0)
    else begin
      errors++;
      $error("FAIL reset_out observed hit=%b val=%h expected hit=00 val=0", bus.rd_hit, bus.rd_val);
    end

    cyc(0, 8'h00, 32'h0, 2'b01, 8'h10, 8'h00, 0); expect_rd(0, 0, 32'h0, 1);
    cyc(1, 8'h10, 32'hAAAA0001, 2'b00, 8'h00, 8'h00, 0);
    cyc(0, 8'h00, 32'h0, 2'b11, 8'h10, 8'h10, 0);
    expect_rd(0, 1, 32'hAAAA0001, 2); expect_rd(1, 1, 32'hAAAA0001, 3);

    cyc(1, 8'h21, 32'h12345678, 2'b00, 8'h00, 8'h00, 0);
    cyc(0, 8'h00, 32'h0, 2'b11, 8'h25, 8'h21, 0);
    expect_rd(0, 0, 32'h0, 4); expect_rd(1, 1, 32'h12345678, 5);

    // Replacement: fill set 0, touch 0x10, then force an eviction with 0x18.
    cyc(0, 8'h00, 32'h0, 2'b00, 8'h00, 8'h00, 1);
    cyc(1, 8'h10, 32'h0000000A, 2'b00, 8'h00, 8'h00, 0);
    cyc(1, 8'h14, 32'h0000000B, 2'b00, 8'h00, 8'h00, 0);
    cyc(0, 8'h00, 32'h0, 2'b01, 8'h10, 8'h00, 0); expect_rd(0, 1, 32'h0000000A, 6);
    cyc(1, 8'h18, 32'h0000000C, 2'b00, 8'h00, 8'h00, 0);
    cyc(0, 8'h00, 32'h0, 2'b11, 8'h14, 8'h10, 0);
    expect_rd(0, !LRU, LRU ? 32'h0 : 32'h0000000B, 7);
    expect_rd(1, LRU, LRU ? 32'h0000000A : 32'h0, 8);
    cyc(0, 8'h00, 32'h0, 2'b11, 8'h18, 8'h21, 0);
    expect_rd(0, 1, 32'h0000000C, 9); expect_rd(1, 0, 32'h0, 10);

    // Read-before-write on the same address.
    cyc(1, 8'h10, 32'h0, 2'b00, 8'h00, 8'h00, 0);
    cyc(1, 8'h10, 32'h1, 2'b01, 8'h10, 8'h00, 0); expect_rd(0, 1, 32'h0, 11);
    cyc(0, 8'h00, 32'h0, 2'b01, 8'h10, 8'h00, 0); expect_rd(0, 1, 32'h1, 12);

    // Flush: same-cycle reads see old state, same-cycle write is dropped.
    cyc(0, 8'h00, 32'h0, 2'b00, 8'h00, 8'h00, 1);
    cyc(1, 8'h10, 32'h0F0F0F0F, 2'b00, 8'h00, 8'h00, 0);
    cyc(1, 8'h14, 32'hF0F0F0F0, 2'b00, 8'h00, 8'h00, 0);
    cyc(1, 8'h18, 32'h00000055, 2'b11, 8'h10, 8'h14, 1);
    expect_rd(0, 1, 32'h0F0F0F0F, 13); expect_rd(1, 1, 32'hF0F0F0F0, 14);
    cyc(0, 8'h00, 32'h0, 2'b11, 8'h10, 8'h14, 0);
    expect_rd(0, 0, 32'h0, 15); expect_rd(1, 0, 32'h0, 16);
    cyc(0, 8'h00, 32'h0, 2'b01, 8'h18, 8'h00, 0); expect_rd(0, 0, 32'h0, 17);

    // Reset mid-stream: no result for the reset cycle, contents invalidated.
    cyc(1, 8'h10, 32'h00000077, 2'b00, 8'h00, 8'h00, 0);
    cyc(0, 8'h00, 32'h0, 2'b11, 8'h10, 8'h10, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.rd_en = 2'b01; bus.rd_addr[0] = 8'h10;
    expect_rd(0, 0, 32'h0, 18);
    repeat (3) cyc(0, 8'h00, 32'h0, 2'b00, 8'h00, 8'h00, 0);
    @(negedge clk);

    checks++;
    assert (sb.size() == 0)
    else begin
      errors++;
      $error("FAIL sb_drain observed=%0d pending expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
